// File: rtl/pos_sweep_eval.sv
// pos_sweep_eval: programmable product-of-sums evaluator with single-shot and
// exhaustive sweep modes; the sweep captures the full truth table on chip.
`default_nettype none

module pos_sweep_eval #(
  parameter int N  = 4,
  parameter int M  = 8,
  parameter int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [N-1:0]      cfg_pos,
  input  logic [N-1:0]      cfg_neg,
  input  logic              cfg_en,
  input  logic              eval_valid,
  input  logic [N-1:0]      eval_in,
  output logic              eval_ready,
  input  logic              sweep_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_in,
  output logic              out_s,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [(1<<N)-1:0] tt,
  output logic [N:0]        ones_cnt
);

  localparam logic [N-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ONE   = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0] pos_m [M];
  logic [N-1:0] neg_m [M];
  logic [M-1:0] en_m;

  logic [N-1:0] f_vec;
  logic [M-1:0] clause_ok;
  logic         f_val;
  logic         cfg_hit;

  // One shared evaluator: the vector to be registered at the next edge.
  always_comb begin
    f_vec = out_in + 1'b1;
    if (state == IDLE) f_vec = sweep_start ? '0 : eval_in;
  end

  for (genvar c = 0; c < M; c++) begin : g_clause
    assign clause_ok[c] = ~en_m[c] | (|((pos_m[c] & f_vec) | (neg_m[c] & ~f_vec)));
  end

  assign f_val   = &clause_ok;
  assign cfg_hit = cfg_we && (state == IDLE) && (32'(cfg_idx) < M);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    eval_ready = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        eval_ready = ~sweep_start;
        if (sweep_start)     state_nxt = SWEEP;
        else if (eval_valid) state_nxt = ONE;
      end
      ONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      SWEEP: begin
        out_valid = 1'b1;
        out_last  = (out_in == LAST_IDX);
        if (out_ready && out_in == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < M; c++) begin
        pos_m[c] <= '0;
        neg_m[c] <= '0;
      end
      en_m     <= '0;
      out_in   <= '0;
      out_s    <= 1'b0;
      tt       <= '0;
      ones_cnt <= '0;
    end else begin
      if (cfg_hit) begin
        pos_m[cfg_idx] <= cfg_pos;
        neg_m[cfg_idx] <= cfg_neg;
        en_m[cfg_idx]  <= cfg_en;
      end
      case (state)
        IDLE: begin
          if (sweep_start) begin
            out_in   <= '0;
            out_s    <= f_val;
            tt       <= '0;
            ones_cnt <= '0;
          end else if (eval_valid) begin
            out_in <= eval_in;
            out_s  <= f_val;
          end
        end
        SWEEP: begin
          if (out_ready) begin
            tt[out_in] <= out_s;
            ones_cnt   <= ones_cnt + {{N{1'b0}}, out_s};
            // Index stays on the last vector; the state change ends the sweep.
            if (out_in != LAST_IDX) begin
              out_in <= f_vec;
              out_s  <= f_val;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pos_sweep_eval.sv
// Self-checking bench for pos_sweep_eval: table-driven single evaluations,
// hand-written sweep sequences and randomized configs against a clause model.
`default_nettype none

module tb_pos_sweep_eval;

  localparam int N  = 4;
  localparam int M  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [N-1:0]  cfg_pos, cfg_neg;
  logic          cfg_en;
  logic          eval_valid;
  logic [N-1:0]  eval_in;
  logic          eval_ready;
  logic          sweep_start;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_in;
  logic          out_s, out_last, busy, done;
  logic [15:0]   tt;
  logic [N:0]    ones_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [N-1:0] m_pos [M];
  logic [N-1:0] m_neg [M];
  logic         m_en  [M];

  typedef struct {
    logic [N-1:0] vin;
    logic         exp_s;
  } vec_t;
  vec_t tab [4];

  pos_sweep_eval #(.N(N), .M(M), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pos(cfg_pos), .cfg_neg(cfg_neg), .cfg_en(cfg_en),
    .eval_valid(eval_valid), .eval_in(eval_in), .eval_ready(eval_ready),
    .sweep_start(sweep_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_in(out_in), .out_s(out_s), .out_last(out_last), .busy(busy),
    .done(done), .tt(tt), .ones_cnt(ones_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A clause is satisfied if any selected literal is true.
  function automatic logic model_f(input logic [N-1:0] v);
    logic sat;
    for (int c = 0; c < M; c++) begin
      if (m_en[c]) begin
        sat = 1'b0;
        for (int i = 0; i < N; i++)
          if ((m_pos[c][i] && v[i]) || (m_neg[c][i] && !v[i])) sat = 1'b1;
        if (!sat) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] model_tt();
    logic [15:0] t;
    for (int k = 0; k < 16; k++) t[k] = model_f(4'(k));
    return t;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < M; c++) begin
      m_pos[c] = '0; m_neg[c] = '0; m_en[c] = 1'b0;
    end
  endfunction

  task automatic write_clause(input int idx, input logic [N-1:0] p, input logic [N-1:0] n, input logic en);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_pos = p; cfg_neg = n; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
    m_pos[idx] = p; m_neg[idx] = n; m_en[idx] = en;
  endtask

  task automatic load_common();
    write_clause(0, 4'b1100, 4'b0000, 1'b1);  // X+Y
    write_clause(1, 4'b1000, 4'b0001, 1'b1);  // X+~Z
    write_clause(2, 4'b1000, 4'b0010, 1'b1);  // X+~W
    write_clause(3, 4'b0000, 4'b0011, 1'b1);  // ~W+~Z
    write_clause(4, 4'b0100, 4'b0010, 1'b1);  // Y+~W
  endtask

  task automatic single_eval(input logic [N-1:0] v, input logic exp, input int hold);
    eval_valid = 1'b1; eval_in = v;
    #1 chk("eval_ready", 32'(eval_ready), 32'd1);
    @(negedge clk);
    eval_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      chk("one_valid", 32'(out_valid), 32'd1);
      chk("one_in", 32'(out_in), 32'(v));
      chk("one_s", 32'(out_s), 32'(exp));
      chk("one_last", 32'(out_last), 32'd0);
      out_ready = (h == hold);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("one_return_idle", 32'({out_valid, busy}), 32'd0);
  endtask

  // Runs one sweep starting at the current negedge. abort_at>=0 asserts reset
  // while that beat is presented; cfg_at>=0 attempts a config write mid-sweep.
  task automatic run_sweep(input int stall_at, input int stall_len, input bit with_eval,
                           input int cfg_at, input int abort_at, input logic [15:0] exp_tt);
    int  exp_idx = 0;
    int  stalled = 0;
    bit  got_done = 0;
    sweep_start = 1'b1;
    eval_valid  = with_eval;
    eval_in     = 4'b1111;
    #1 chk("start_eval_ready", 32'(eval_ready), 32'd0);
    for (int cyc = 1; cyc <= 60 && !got_done; cyc++) begin
      @(negedge clk);
      sweep_start = 1'b0;
      eval_valid  = 1'b0;
      cfg_we      = 1'b0;
      if (exp_idx <= 15) begin
        chk("beat_valid", 32'(out_valid), 32'd1);
        chk("beat_in", 32'(out_in), 32'(exp_idx));
        chk("beat_s", 32'(out_s), 32'(model_f(4'(exp_idx))));
        chk("beat_last", 32'(out_last), 32'(exp_idx == 15));
        chk("beat_done", 32'(done), 32'd0);
        if (exp_idx == abort_at) begin
          rst_n = 1'b0; out_ready = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          model_clear();
          chk("abort_state", 32'({out_valid, busy, done, out_in, out_s}), 32'd0);
          chk("abort_tt", 32'(tt), 32'd0);
          chk("abort_ones", 32'(ones_cnt), 32'd0);
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({done, busy}), 32'd0);
          end
          return;
        end
        if (exp_idx == cfg_at) begin
          cfg_we = 1'b1; cfg_idx = 3'd7; cfg_pos = '0; cfg_neg = '0; cfg_en = 1'b1;
        end
        if (exp_idx == stall_at && stalled < stall_len) begin
          out_ready = 1'b0; stalled++;
        end else begin
          out_ready = 1'b1; exp_idx++;
        end
      end else begin
        chk("done_pulse", 32'({done, out_valid}), 32'b10);
        chk("done_cycle", 32'(cyc), 32'(17 + stall_len));
        chk("sweep_tt", 32'(tt), 32'(exp_tt));
        chk("sweep_ones", 32'(ones_cnt), 32'($countones(exp_tt)));
        got_done  = 1'b1;
        out_ready = 1'b0;
      end
    end
    if (!got_done) chk("sweep_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("after_done", 32'({done, busy}), 32'd0);
  endtask

  initial begin
    logic [N-1:0] v;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_pos = '0; cfg_neg = '0; cfg_en = 1'b0;
    eval_valid = 1'b0; eval_in = '0; sweep_start = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'({out_valid, out_in, out_s, out_last, done, busy}), 32'd0);
    chk("rst_tt", 32'(tt), 32'd0);
    chk("rst_ones", 32'(ones_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    load_common();
    tab[0] = '{4'b0100, 1'b1};
    tab[1] = '{4'b1111, 1'b0};
    tab[2] = '{4'b1010, 1'b0};
    tab[3] = '{4'b1110, 1'b1};
    for (int i = 0; i < 4; i++) single_eval(tab[i].vin, tab[i].exp_s, i);

    run_sweep(-1, 0, 1'b0, -1, -1, 16'h7310);
    run_sweep(5, 3, 1'b0, -1, -1, 16'h7310);

    // Single evaluations must leave the captured truth table alone.
    for (int i = 0; i < 20; i++) begin
      v = 4'($urandom);
      single_eval(v, model_f(v), int'($urandom_range(0, 2)));
    end
    chk("tt_persist", 32'(tt), 32'h7310);
    chk("ones_persist", 32'(ones_cnt), 32'd6);

    run_sweep(-1, 0, 1'b0, 3, -1, 16'h7310);
    run_sweep(-1, 0, 1'b1, -1, -1, 16'h7310);

    for (int c = 0; c < 5; c++) write_clause(c, m_pos[c], m_neg[c], 1'b0);
    run_sweep(-1, 0, 1'b0, -1, -1, 16'hFFFF);
    write_clause(7, 4'b0000, 4'b0000, 1'b1);
    run_sweep(-1, 0, 1'b0, -1, -1, 16'h0000);

    write_clause(7, 4'b0000, 4'b0000, 1'b0);
    load_common();
    run_sweep(-1, 0, 1'b0, -1, 8, 16'h0000);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < M; c++)
        write_clause(c, 4'($urandom), 4'($urandom), ($urandom_range(0, 2) == 0));
      run_sweep(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, -1, -1, model_tt());
      for (int i = 0; i < 4; i++) begin
        v = 4'($urandom);
        single_eval(v, model_f(v), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pos_sweep_eval.md
Name: pos_sweep_eval

Overview:
- Parametrised, clocked successor to the fixed 4-input product-of-sums gates.
- Holds up to M programmable OR-clauses over N inputs and evaluates s = AND of the enabled clauses.
- Single-evaluation mode: one input vector per valid/ready request.
- Sweep mode: walks all 2^N input combinations, streams (vector, s) pairs and captures the complete truth table on chip, replacing the hand-written exhaustive testbench sweeps.

Parameters:
- N, default 4: number of input variables; in[N-1] is the first/leftmost variable.
- M, default 8: number of clause slots.
- IW, default $clog2(M) (minimum 1): clause index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  clause write strobe
- cfg_idx  in  IW  clause slot to write
- cfg_pos  in  N  bit i=1: literal in[i] is in the clause
- cfg_neg  in  N  bit i=1: literal ~in[i] is in the clause
- cfg_en  in  1  clause enable written with the masks
- eval_valid  in  1  single-evaluation request
- eval_in  in  N  vector to evaluate
- eval_ready  out  1  request accepted when eval_valid & eval_ready
- sweep_start  in  1  start exhaustive sweep (sampled only in IDLE)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_in  out  N  vector that produced out_s
- out_s  out  1  function value
- out_last  out  1  final sweep beat (index 2^N-1)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after a sweep's last beat is accepted
- tt  out  2^N  truth table, tt[k] = f(k)
- ones_cnt  out  N+1  number of 1s in tt

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all clause slots cleared (pos=neg=0, en=0); state=IDLE.
  - out_valid, out_in, out_s, out_last, done, tt and ones_cnt all 0.
  - Applies in any state, including mid-sweep; the sweep is abandoned with no done pulse.
- Function:
  - clause c = OR over i of (pos[i]&in[i]) | (neg[i]&~in[i]).
  - A disabled clause contributes 1.
  - An enabled clause with both masks 0 contributes 0.
  - No enabled clauses: f = 1.
- Config:
  - cfg_we writes slot cfg_idx only in IDLE; ignored when busy.
  - cfg_idx >= M is ignored.
  - A write takes effect for requests accepted on the following cycle or later.
- States: IDLE, ONE, SWEEP, DONE.
- IDLE:
  - eval_ready = ~sweep_start.
  - sweep_start=1: go to SWEEP; index <= 0, tt <= 0, ones_cnt <= 0. sweep_start wins over a simultaneous eval_valid.
  - Else eval_valid=1: register eval_in and f(eval_in), go to ONE.
- ONE:
  - out_valid=1, out_last=0, latency 1 cycle from acceptance.
  - out_in and out_s stay stable until out_ready=1, then return to IDLE. No back-to-back accept in that same cycle.
- SWEEP:
  - out_valid=1, out_in=index, out_s=f(index), out_last=(index==2^N-1).
  - On out_ready=1: tt[index] <= out_s, ones_cnt += out_s, then index+1, or go to DONE after the last beat.
  - out_ready=0: all outputs held stable.
  - The index never wraps.
- DONE: done=1 for exactly one cycle, out_valid=0, then go to IDLE.
- Results persist:
  - tt and ones_cnt hold their values until the next sweep_start or reset.
  - Single evaluations do not modify tt or ones_cnt.
- Timing: with out_ready held at 1, sweep_start accepted at edge t gives beats at cycles t+1..t+2^N and done at t+2^N+1.
- Registered outputs only; no combinational path from inputs to outputs except eval_ready from sweep_start.

Test Plan:
- Common config for the scenarios below, with N=4 and in=XYWZ (X=in[3]): load clauses (X+Y), (X+~Z), (X+~W), (~W+~Z), (Y+~W) into slots 0-4.
- Single evaluation: eval_in=4'b0100 -> out_s=1 one cycle later. eval_in=4'b1111 -> 0. eval_in=4'b1010 -> 0. eval_in=4'b1110 -> 1.
- Full sweep with out_ready=1:
  - 16 beats with out_in 0..15; out_last only on 15.
  - done pulses at t+17.
  - tt=16'h7310, ones_cnt=6.
- Backpressure: drop out_ready for 3 cycles while out_in=5 -> out_in=5 and out_s=0 held. The final result is still tt=16'h7310 and the done pulse is delayed by 3 cycles.
- Edge functions:
  - All slots disabled -> tt=16'hFFFF, ones_cnt=16.
  - Enable slot 7 with empty masks -> tt=0, ones_cnt=0.
  - sweep_start and eval_valid together -> sweep runs and eval_ready=0.
- Reset and config lockout:
  - rst_n=0 during beat 8 -> next cycle IDLE with out_valid=0, tt=0, ones_cnt=0, and no done pulse.
  - cfg_we during a sweep -> ignored; result unchanged.
